// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_pkg
// Description : Shared types and default sizing for the DMA transfer
//               controller. It holds the controller state encoding and the
//               default values for the length width and the grant-wait
//               limit.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_pkg;

  localparam int DMA_LEN_W_DEFAULT    = 8;
  localparam int DMA_MAX_WAIT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } dma_state_e;

endpackage
`default_nettype wire

// File: rtl/dma_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : dma_wait_timer
// Description : Grant-wait counter. It counts the enabled cycles since the
//               last clear. expired is high while the count equals
//               MAX_WAIT-1, and the count saturates there.
// Ports       : clk, reset_n  - clock, asynchronous active-low reset
//               clear         - synchronous clear (has priority over enable)
//               enable        - count this cycle
//               expired       - count has reached MAX_WAIT-1
// Revision    : 1.0 - initial release
// ============================================================================
module dma_wait_timer
  import dma_pkg::*;
#(
  parameter int MAX_WAIT = DMA_MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // The legal MAX_WAIT range is 2..255, so 8 bits always suffices.
  localparam logic [7:0] LAST_CNT = 8'(MAX_WAIT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign expired = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dma_xfer_ctrl
// Description : Single-channel DMA transfer controller. A go pulse in IDLE
//               requests the bus (REQ). After a grant, the controller moves
//               xfer_len beats gated by data_ready (XFER). It then pulses
//               done (DONE) and returns to IDLE. If the grant does not
//               arrive within MAX_WAIT cycles, the controller pulses
//               timeout_err and returns to IDLE.
// Ports       : clk, reset_n     - clock, asynchronous active-low reset
//               go, xfer_len     - start pulse and beat count
//               dma_gnt          - arbiter grant
//               data_ready       - downstream accepts a beat this cycle
//               dma_req          - bus request
//               data_transfer    - a beat moves this cycle
//               beat_cnt         - beats completed in current transfer
//               busy, done       - activity flag, completion pulse
//               timeout_err      - grant-wait expiry pulse
// Revision    : 1.0 - initial release
// ============================================================================
module dma_xfer_ctrl
  import dma_pkg::*;
#(
  parameter int LEN_W    = DMA_LEN_W_DEFAULT,
  parameter int MAX_WAIT = DMA_MAX_WAIT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [LEN_W-1:0] xfer_len,
  input  logic             dma_gnt,
  input  logic             data_ready,
  output logic             dma_req,
  output logic             data_transfer,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  dma_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             timeout_q, timeout_d;

  logic             timer_clear;
  logic             timer_enable;
  logic             timer_expired;

  // Holding the timer clear through IDLE means it always starts REQ at zero.
  assign timer_clear  = (state_q == ST_IDLE);
  assign timer_enable = (state_q == ST_REQ) && !dma_gnt;

  dma_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          beat_cnt_d = '0;
          if (xfer_len != '0) begin
            len_d   = xfer_len;
            state_d = ST_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        // A grant in the expiry cycle takes precedence over the timeout.
        if (dma_gnt) begin
          state_d = ST_XFER;
        end else if (timer_expired) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      ST_XFER: begin
        if (data_ready) begin
          beat_cnt_d = beat_cnt_q + LEN_W'(1);
          // The last beat leaves XFER, so the count stops at len_q.
          if (beat_cnt_q == len_q - LEN_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      beat_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Control outputs come from registered state only. data_transfer is the
  // single combinational path, from data_ready, and only while in XFER.
  assign dma_req       = (state_q == ST_REQ) || (state_q == ST_XFER);
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign timeout_err   = timeout_q;
  assign beat_cnt      = beat_cnt_q;
  assign data_transfer = (state_q == ST_XFER) && data_ready;

endmodule
`default_nettype wire

// File: tb/tb_dma_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_xfer_ctrl
// Description : Self-checking bench for dma_xfer_ctrl. For each scenario,
//               the bench derives the expected per-cycle outputs from the
//               transfer timeline: the go cycle, the grant cycle, and the
//               cycle of the last accepted beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_xfer_ctrl;

  localparam int LEN_W    = 8;
  localparam int MAX_WAIT = 16;
  localparam int NRDY     = 512;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             go;
  logic [LEN_W-1:0] xfer_len;
  logic             dma_gnt;
  logic             data_ready;
  logic             dma_req;
  logic             data_transfer;
  logic [LEN_W-1:0] beat_cnt;
  logic             busy;
  logic             done;
  logic             timeout_err;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dma_xfer_ctrl #(
    .LEN_W    (LEN_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .go            (go),
    .xfer_len      (xfer_len),
    .dma_gnt       (dma_gnt),
    .data_ready    (data_ready),
    .dma_req       (dma_req),
    .data_transfer (data_transfer),
    .beat_cnt      (beat_cnt),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err)
  );

  // Each cycle the bench steps to 1ns after the edge, drives, then samples at +2ns.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Transfer timeline: go in cycle 0, grant in cycle G=1+gd, beats in
  // ready cycles after G, last beat in cycle E, done in cycle E+1.
  task automatic run_transfer(input int len, input int gd, input int ready_pct,
                              input bit use_pat, input logic [15:0] pat,
                              input bit go_noise, input string name);
    bit rdy [NRDY];
    int g_cyc;
    int e_cyc;
    int cnt;
    int beats;
    logic [4:0] exp_v;
    logic [4:0] act_v;
    g_cyc = 1 + gd;
    for (int c = 0; c < NRDY; c++) begin
      rdy[c] = ($urandom_range(99) < ready_pct);
      if (c > g_cyc + 3 * len + 8) rdy[c] = 1'b1;
      if (use_pat && c > g_cyc) rdy[c] = (c - g_cyc - 1 < 16) ? pat[c - g_cyc - 1] : 1'b1;
    end
    e_cyc = NRDY - 3;
    cnt   = 0;
    for (int c = g_cyc + 1; c < NRDY - 3; c++) begin
      if (rdy[c]) cnt++;
      if (cnt == len) begin
        e_cyc = c;
        break;
      end
    end
    for (int c = 0; c <= e_cyc + 3; c++) begin
      next_cycle();
      if (c == 0) begin
        go       = 1'b1;
        xfer_len = LEN_W'(len);
      end else begin
        go       = go_noise && (c <= e_cyc + 1) && ($urandom_range(1) == 1);
        xfer_len = LEN_W'($urandom_range(255));
      end
      if (c < g_cyc)       dma_gnt = 1'b0;
      else if (c == g_cyc) dma_gnt = 1'b1;
      else                 dma_gnt = LEN_W'($urandom_range(1)) != '0;
      data_ready = rdy[c];
      #1;
      exp_v[4] = (c >= 1) && (c <= e_cyc);
      exp_v[3] = (c > g_cyc) && (c <= e_cyc) && rdy[c];
      exp_v[2] = (c >= 1) && (c <= e_cyc + 1);
      exp_v[1] = (c == e_cyc + 1);
      exp_v[0] = 1'b0;
      act_v    = {dma_req, data_transfer, busy, done, timeout_err};
      n_run++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s cycle %0d {req,xfer,busy,done,terr} got %b want %b", name, c, act_v, exp_v);
      end
      if (c >= 1) begin
        beats = 0;
        for (int k = g_cyc + 1; k <= c - 1 && k <= e_cyc; k++) if (rdy[k]) beats++;
        n_run++;
        if (beat_cnt !== LEN_W'(beats)) begin
          n_fail++;
          $display("FAIL %s cycle %0d beat_cnt got %0d want %0d", name, c, beat_cnt, beats);
        end
      end
    end
    go      = 1'b0;
    dma_gnt = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    go         = 1'b1;
    xfer_len   = 8'd5;
    dma_gnt    = 1'b1;
    data_ready = 1'b1;
    repeat (2) begin
      #1;
      n_run++;
      if ({dma_req, data_transfer, busy, done, timeout_err} !== 5'b0 || beat_cnt !== '0) begin
        n_fail++;
        $display("FAIL reset outputs got %b cnt %0d want 00000 cnt 0",
                 {dma_req, data_transfer, busy, done, timeout_err}, beat_cnt);
      end
      @(posedge clk);
      #1;
    end
    go         = 1'b0;
    dma_gnt    = 1'b0;
    data_ready = 1'b0;
    reset_n    = 1'b1;
  endtask

  task automatic test_basic();
    // go with len 4, grant in cycle 3, ready held high: done in cycle 8.
    run_transfer(4, 2, 100, 1'b0, 16'h0, 1'b0, "basic");
  endtask

  task automatic test_stall();
    // Ready pattern 1,0,0,1,1 from the first XFER cycle.
    run_transfer(3, 0, 100, 1'b1, 16'b0000_0000_0001_1001, 1'b0, "stall");
  endtask

  task automatic test_timeout();
    logic [4:0] exp_v;
    logic [4:0] act_v;
    for (int c = 0; c <= MAX_WAIT + 3; c++) begin
      next_cycle();
      go         = (c == 0);
      xfer_len   = LEN_W'($urandom_range(1, 255));
      dma_gnt    = 1'b0;
      data_ready = LEN_W'($urandom_range(1)) != '0;
      #1;
      exp_v = {(c >= 1 && c <= MAX_WAIT), 1'b0, (c >= 1 && c <= MAX_WAIT), 1'b0, (c == MAX_WAIT + 1)};
      act_v = {dma_req, data_transfer, busy, done, timeout_err};
      n_run++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL timeout cycle %0d {req,xfer,busy,done,terr} got %b want %b", c, act_v, exp_v);
      end
    end
    go = 1'b0;
  endtask

  task automatic test_zero_len();
    logic [4:0] exp_v;
    logic [4:0] act_v;
    for (int c = 0; c <= 3; c++) begin
      next_cycle();
      go         = (c == 0);
      xfer_len   = '0;
      dma_gnt    = LEN_W'($urandom_range(1)) != '0;
      data_ready = LEN_W'($urandom_range(1)) != '0;
      #1;
      exp_v = {1'b0, 1'b0, (c == 1), (c == 1), 1'b0};
      act_v = {dma_req, data_transfer, busy, done, timeout_err};
      n_run++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL zero_len cycle %0d {req,xfer,busy,done,terr} got %b want %b", c, act_v, exp_v);
      end
    end
    go      = 1'b0;
    dma_gnt = 1'b0;
  endtask

  task automatic test_gnt_at_expiry();
    // The grant arrives in the last allowed REQ cycle, or one cycle earlier.
    run_transfer(5, MAX_WAIT - 1, 70, 1'b0, 16'h0, 1'b0, "gnt_expiry");
    run_transfer(2, MAX_WAIT - 2, 100, 1'b0, 16'h0, 1'b0, "gnt_pre_expiry");
  endtask

  task automatic test_go_ignored();
    run_transfer(12, 3, 60, 1'b0, 16'h0, 1'b1, "go_ignored");
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 4; c++) begin
      next_cycle();
      go         = (c == 0);
      xfer_len   = 8'd8;
      dma_gnt    = (c == 1);
      data_ready = 1'b1;
    end
    #1;
    n_run++;
    if (beat_cnt !== 8'd2 || data_transfer !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid pre beat_cnt got %0d xfer %b want 2 1", beat_cnt, data_transfer);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_run++;
    if ({dma_req, data_transfer, busy, done, timeout_err} !== 5'b0 || beat_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_async outputs got %b cnt %0d want 00000 cnt 0",
               {dma_req, data_transfer, busy, done, timeout_err}, beat_cnt);
    end
    repeat (2) begin
      next_cycle();
      #1;
      n_run++;
      if ({dma_req, data_transfer, busy, done, timeout_err} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold outputs got %b want 00000",
                 {dma_req, data_transfer, busy, done, timeout_err});
      end
    end
    data_ready = 1'b0;
    reset_n    = 1'b1;
    run_transfer(5, 0, 100, 1'b0, 16'h0, 1'b0, "post_reset");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      run_transfer($urandom_range(1, 40), $urandom_range(0, MAX_WAIT - 1),
                   $urandom_range(30, 100), 1'b0, 16'h0, $urandom_range(1) == 1, "random");
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    go         = 1'b0;
    xfer_len   = '0;
    dma_gnt    = 1'b0;
    data_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_timeout();
    test_zero_len();
    test_gnt_at_expiry();
    test_go_ignored();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
